// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and decode helper for the instruction-fetch slice.
package fetch_unit_pkg;

    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] PC_INC    = 16'd2;

    typedef enum logic [1:0] {
        ST_REQ    = 2'b00,
        ST_BLOCK  = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit_out_buf.sv
// One-entry output buffer feeding IF/ID; squash beats load, load beats consume.
module fetch_out_buf #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc_inc,
    input  logic        consume,
    input  logic        squash,
    output logic [15:0] instr,
    output logic [15:0] pc_inc,
    output logic        halt,
    output logic        valid
);
    import fetch_unit_pkg::*;

    logic [15:0] instr_buf_reg;
    logic [15:0] pcinc_buf_reg;
    logic        halt_buf_reg;
    logic        valid_reg;

    // pc_inc is deliberately left untouched when the buffer empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_buf_reg <= NOP_INSTR;
            pcinc_buf_reg <= 16'h0000;
            halt_buf_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end else if (squash) begin
            instr_buf_reg <= NOP_INSTR;
            halt_buf_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end else if (load) begin
            instr_buf_reg <= load_instr;
            pcinc_buf_reg <= load_pc_inc;
            halt_buf_reg  <= is_halt(load_instr);
            valid_reg     <= 1'b1;
        end else if (consume && valid_reg) begin
            instr_buf_reg <= NOP_INSTR;
            halt_buf_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end
    end

    assign instr  = instr_buf_reg;
    assign pc_inc = pcinc_buf_reg;
    assign halt   = halt_buf_reg;
    assign valid  = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: owns the PC, drives a stalling imem and fills the IF/ID buffer.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        in_stall_n,
    input  logic        take_new_PC,
    input  logic [15:0] new_PC,
    output logic [15:0] out_instr,
    output logic [15:0] out_PC_inc,
    output logic        out_halt,
    output logic        out_valid,
    output logic        err
);
    import fetch_unit_pkg::*;

    fetch_state_t state_reg;
    logic [15:0]  pc_reg;
    logic [15:0]  hold_addr_reg;
    logic         pend_reg;
    logic         rd_reg;

    logic         buf_valid;
    logic         fetch_done;
    logic         accept;
    logic         consume;

    assign fetch_done = rd_reg & imem_done;
    assign accept     = fetch_done & ~pend_reg & ~take_new_PC;
    assign consume    = buf_valid & in_stall_n;

    // A request only exists in REQ; after every accepted fetch the buffer is full,
    // so the FSM parks in BLOCK until IF/ID takes the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_REQ;
            pc_reg        <= RESET_PC;
            hold_addr_reg <= RESET_PC;
            pend_reg      <= 1'b0;
            rd_reg        <= 1'b0;
        end else if (take_new_PC) begin
            pc_reg    <= new_PC;
            state_reg <= ST_REQ;
            rd_reg    <= 1'b1;
            // An in-flight access must finish on its original address; its data is dropped.
            if (rd_reg && !imem_done) begin
                pend_reg <= 1'b1;
                if (!pend_reg) begin
                    hold_addr_reg <= pc_reg;
                end
            end else begin
                pend_reg <= 1'b0;
            end
        end else if (fetch_done && pend_reg) begin
            pend_reg <= 1'b0;
        end else if (accept) begin
            pc_reg <= pc_reg + PC_INC;
            rd_reg <= 1'b0;
            if (is_halt(imem_data)) begin
                state_reg <= ST_HALTED;
            end else begin
                state_reg <= ST_BLOCK;
            end
        end else if (state_reg == ST_BLOCK && consume) begin
            state_reg <= ST_REQ;
            rd_reg    <= 1'b1;
        end else if (state_reg == ST_REQ) begin
            rd_reg <= 1'b1;
        end
    end

    fetch_out_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept),
        .load_instr  (imem_data),
        .load_pc_inc (pc_reg + PC_INC),
        .consume     (consume),
        .squash      (take_new_PC),
        .instr       (out_instr),
        .pc_inc      (out_PC_inc),
        .halt        (out_halt),
        .valid       (buf_valid)
    );

    assign out_valid = buf_valid;
    assign imem_rd   = rd_reg;
    assign imem_addr = pend_reg ? hold_addr_reg : pc_reg;

    assign err = (^{clk, rst_n, imem_data, imem_done, in_stall_n, take_new_PC, new_PC} === 1'bx);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch engine that produces the (instr, PC_inc, halt) triple consumed by the IF/ID pipeline register. It is the write side of that interface.
- Owns the PC and drives a stalling instruction memory (rd/done handshake).
- Buffers one fetched instruction when downstream stalls.
- Applies branch/jump redirects (take_new_PC / new_PC) and stops fetching after HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- NOP_INSTR, 16'h0800, instruction driven when no valid fetch (opcode 00001).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  16  instruction memory address (current PC)
- imem_rd  out  1  read request; held with stable addr until imem_done
- imem_data  in  16  read data, valid only in imem_done cycle
- imem_done  in  1  read complete; earliest one cycle after imem_rd first rises
- in_stall_n  in  1  IF/ID write enable, active low stall; 1 = IF/ID captures outputs this edge
- take_new_PC  in  1  redirect request from execute
- new_PC  in  16  redirect target
- out_instr  out  16  instruction to IF/ID
- out_PC_inc  out  16  PC+2 of out_instr
- out_halt  out  1  out_instr is HALT (opcode 00000)
- out_valid  out  1  buffer holds a real instruction
- err  out  1  high when any input is X/Z

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=REQ, redirect_pending=0.
  - Buffer empty: out_instr=NOP_INSTR, out_PC_inc=0, out_halt=0, out_valid=0.
  - imem_rd=0 while rst_n=0.
  - Reset mid-access discards the access.
- States:
  - REQ: imem_rd=1, imem_addr=PC.
  - BLOCK: no request; buffer full and not consumable.
  - HALTED: no request.
- Buffer register: instr_buf, pcinc_buf, halt_buf, valid. All outputs are driven directly from it (registered outputs).
- When empty: out_instr=NOP_INSTR, out_halt=0, out_valid=0. out_PC_inc holds its last value.
- Consume: valid & in_stall_n=1 at an edge clears valid unless a new fetch lands the same edge.
- Fetch completion in REQ with imem_done=1 and no redirect (redirect_pending=0, take_new_PC=0), when the buffer is empty or being consumed:
  - buffer <= {imem_data, PC+2, imem_data[15:11]==5'b00000}, valid=1.
  - PC <= PC+2; arithmetic is modulo 2^16 (16'hFFFE + 2 = 16'h0000).
  - If the fetched instruction is HALT: state<=HALTED. Otherwise stay in REQ.
- imem_done with the buffer full and not consumed cannot occur, because REQ is entered only when space exists.
- From REQ after completion, if the buffer would still be full next cycle: state<=BLOCK.
- BLOCK -> REQ on the edge where the buffer is consumed.
- Throughput: one instruction per imem_done. Latency: imem_done edge -> out_valid next cycle.
- take_new_PC=1 (priority over in_stall_n and imem_done):
  - valid<=0 (squash), out_halt<=0, PC<=new_PC.
  - From HALTED or BLOCK: state<=REQ.
  - In REQ with an access outstanding and imem_done=0 this cycle: redirect_pending<=1, keep imem_rd and the old addr until done.
  - The returning data is discarded. redirect_pending<=0, then a new access to new_PC starts the next cycle.
  - With imem_done=1 in the same cycle: the data is discarded and the next access targets new_PC.
- A second take_new_PC while pending overwrites PC; the last target wins.
- HALT: HALTED makes no further requests. The halt instruction stays in the buffer (out_halt=1) until consumed. After consumption, outputs are NOP with out_valid=0 indefinitely; only take_new_PC or reset exits.
- err = (^{all inputs} === 1'bX).

Decomposition:
- Shared package/include holds:
  - OPC_HALT=5'b00000, NOP_INSTR=16'h0800, PC increment constant 2.
  - State encodings REQ/BLOCK/HALTED, 2 bits.
- Sub-module fetch_out_buf: the 1-entry output buffer with load/consume/squash.
- PC and state use the existing register primitive with writeEn.

Test Plan:
- Reset then done every 2nd cycle, imem at 0,2,4 = 16'h4000,16'h4801,16'h5002, in_stall_n=1 -> out_instr sequence 4000,4801,5002 with out_PC_inc 2,4,6; out_valid one cycle after each done.
- Buffer holding 16'h4000, in_stall_n=0 for 5 cycles -> outputs stable, state BLOCK, imem_rd=0. Release -> imem_rd rises the same cycle, addr=2.
- Access to PC=4 outstanding, take_new_PC=1 new_PC=16'h0100, done 3 cycles later with 16'h1234 -> 1234 never appears on outputs; next imem_addr=16'h0100; buffer squashed immediately.
- imem returns 16'h0000 at PC=6 -> out_halt=1, out_PC_inc=8, no further imem_rd. After consume -> out_instr=16'h0800, out_valid=0. take_new_PC to 16'h0020 -> fetch resumes at 0020.
- PC=16'hFFFE fetch -> out_PC_inc=16'h0000, next imem_addr=16'h0000.
- rst_n pulsed low mid-access with buffer valid -> outputs immediately NOP/0/0/0, imem_rd=0. After release, fetch restarts at RESET_PC.
